voice_motion_ctrl: RTL and testbench

Consumes the per-frame `pitch` and `volumn` classifications from the signal analyser and turns them into player-sprite motion for the game renderer. Volume must persist for at least two of three frames before it counts as voice, which filters out clicks. Low pitch walks the sprite; mid and high pitch launch jumps of two fixed heights. All state advances once per frame on a single-cycle `frame_tick` enable in the system clock domain.

---
 rtl/voice_game_pkg.sv | 22 ++
 rtl/volume_debounce.sv | 33 +++
 rtl/voice_motion_ctrl.sv | 135 +++++++++++++
 tb/tb_voice_motion_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_game_pkg.sv
// Shared definitions for the voice-driven sprite motion block.
// Holds the motion FSM state encoding, the analyser pitch codes and the
// default geometry (horizontal extent, jump apex heights, vertical step).
package voice_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RISE = 2'd2,
        FALL = 2'd3
    } motion_state_t;

    localparam logic [1:0] PITCH_LOW  = 2'b00;
    localparam logic [1:0] PITCH_MID  = 2'b01;
    localparam logic [1:0] PITCH_HIGH = 2'b11;

    localparam int unsigned X_MAX_DEF     = 319;
    localparam int unsigned JUMP_MID_DEF  = 16;
    localparam int unsigned JUMP_HIGH_DEF = 32;
    localparam int unsigned STEP_Y_DEF    = 2;

endpackage

// File: rtl/volume_debounce.sv
// Volume click filter.
// Keeps a two-frame history of the loud flag and reports a 2-of-3 majority
// over {two previous frames, current frame}, valid only on an accepted tick.
//   clk     : system clock
//   resetn  : asynchronous active-low reset (clears history)
//   tick    : accepted frame tick (one cycle)
//   volumn  : loud flag for the current frame
//   vol_ok  : majority result, qualified by tick
module volume_debounce
    import voice_game_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic volumn,
    output logic vol_ok
);

    logic [1:0] vh;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vh <= '0;
        end else if (tick) begin
            vh <= {vh[0], volumn};
        end
    end

    always_comb begin
        vol_ok = tick & ((vh[1] & vh[0]) | (vh[1] & volumn) | (vh[0] & volumn));
    end

endmodule

// File: rtl/voice_motion_ctrl.sv
// Voice-controlled sprite motion.
// Turns per-frame pitch/volume classes into walking and jumping motion.
// All state advances only on accepted frame ticks.
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   frame_tick : one-cycle pulse per frame
//   pitch      : 00 low, 01 mid, 11 high, 10 treated as low
//   volumn     : loud flag for the current frame
//   x_pos      : horizontal position, wraps after X_MAX
//   height     : height above ground
//   state      : IDLE/WALK/RISE/FALL
//   landed     : one-cycle pulse after the landing tick
module voice_motion_ctrl
    import voice_game_pkg::*;
#(
    parameter int unsigned X_MAX     = X_MAX_DEF,
    parameter int unsigned JUMP_MID  = JUMP_MID_DEF,
    parameter int unsigned JUMP_HIGH = JUMP_HIGH_DEF,
    parameter int unsigned STEP_Y    = STEP_Y_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [1:0] pitch,
    input  logic       volumn,
    output logic [8:0] x_pos,
    output logic [5:0] height,
    output logic [1:0] state,
    output logic       landed
);

    motion_state_t st;
    logic          armed;
    logic          tick;
    logic          vol_ok;
    logic [5:0]    apex;
    logic          tgt_valid;
    logic [5:0]    tgt;
    logic [8:0]    x_next;
    logic [6:0]    h_up;
    logic [5:0]    h_rise;
    logic [5:0]    h_fall;

    // armed stays low for the first edge after reset release, so a tick
    // landing on that edge is dropped regardless of reset/clock skew.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    assign tick  = frame_tick & armed;
    assign state = st;

    volume_debounce u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick),
        .volumn (volumn),
        .vol_ok (vol_ok)
    );

    always_comb begin
        tgt_valid = 1'b0;
        tgt       = '0;
        if (pitch == PITCH_HIGH) begin
            tgt_valid = 1'b1;
            tgt       = 6'(JUMP_HIGH);
        end else if (pitch == PITCH_MID) begin
            tgt_valid = 1'b1;
            tgt       = 6'(JUMP_MID);
        end
    end

    // Height math in 7 bits so the step can never wrap before saturation.
    always_comb begin
        x_next = (x_pos == 9'(X_MAX)) ? '0 : x_pos + 9'd1;
        h_up   = {1'b0, height} + 7'(STEP_Y);
        h_rise = (h_up > {1'b0, apex}) ? apex : h_up[5:0];
        h_fall = ({1'b0, height} >= 7'(STEP_Y)) ? 6'(height - 6'(STEP_Y)) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st     <= IDLE;
            x_pos  <= '0;
            height <= '0;
            apex   <= '0;
            landed <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (tick) begin
                case (st)
                    IDLE: begin
                        height <= '0;
                        if (vol_ok && tgt_valid) begin
                            st   <= RISE;
                            apex <= tgt;
                        end else if (vol_ok) begin
                            st <= WALK;
                        end
                    end
                    WALK: begin
                        x_pos <= x_next;
                        if (!vol_ok) begin
                            st <= IDLE;
                        end else if (tgt_valid) begin
                            st   <= RISE;
                            apex <= tgt;
                        end
                    end
                    RISE: begin
                        x_pos  <= x_next;
                        height <= h_rise;
                        if (h_rise == apex) begin
                            st <= FALL;
                        end
                    end
                    FALL: begin
                        x_pos  <= x_next;
                        height <= h_fall;
                        if (h_fall == '0) begin
                            landed <= 1'b1;
                            st     <= vol_ok ? WALK : IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_motion_ctrl.sv
// Self-checking bench for voice_motion_ctrl: directed scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_voice_motion_ctrl;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic [1:0] pitch;
    logic       volumn;
    logic [8:0] x_pos;
    logic [5:0] height;
    logic [1:0] state;
    logic       landed;

    int tests_run;
    int tests_failed;

    // reference model state
    int m_state;   // 0 idle, 1 walk, 2 rise, 3 fall
    int m_x;
    int m_h;
    int m_apex;
    int m_landed;
    bit m_armed;
    int m_hist[$];

    voice_motion_ctrl #(
        .X_MAX     (319),
        .JUMP_MID  (16),
        .JUMP_HIGH (32),
        .STEP_Y    (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .pitch      (pitch),
        .volumn     (volumn),
        .x_pos      (x_pos),
        .height     (height),
        .state      (state),
        .landed     (landed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_x      = 0;
        m_h      = 0;
        m_apex   = 0;
        m_landed = 0;
        m_armed  = 1'b0;
        m_hist.delete();
    endtask

    // One rising clock edge with reset released.
    task automatic model_step(input bit t, input int p, input int v);
        int loud;
        int tgt;
        bit ok;
        m_landed = 0;
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        if (!t) return;
        loud = v;
        foreach (m_hist[i]) loud += m_hist[i];
        ok = (loud >= 2);
        m_hist.push_back(v);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        tgt = (p == 3) ? 32 : (p == 1) ? 16 : 0;
        case (m_state)
            0: begin
                if (ok && tgt != 0) begin m_state = 2; m_apex = tgt; end
                else if (ok) m_state = 1;
            end
            1: begin
                m_x = (m_x + 1) % 320;
                if (!ok) m_state = 0;
                else if (tgt != 0) begin m_state = 2; m_apex = tgt; end
            end
            2: begin
                m_x = (m_x + 1) % 320;
                m_h = (m_h + 2 > m_apex) ? m_apex : m_h + 2;
                if (m_h == m_apex) m_state = 3;
            end
            default: begin
                m_x = (m_x + 1) % 320;
                m_h = (m_h < 2) ? 0 : m_h - 2;
                if (m_h == 0) begin
                    m_landed = 1;
                    m_state  = ok ? 1 : 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("state",  int'(state),  m_state);
        check_eq("x_pos",  int'(x_pos),  m_x);
        check_eq("height", int'(height), m_h);
        check_eq("landed", int'(landed), m_landed);
    endtask

    task automatic cycle(input bit t, input logic [1:0] p, input bit v);
        @(negedge clk);
        frame_tick = t;
        pitch      = p;
        volumn     = v;
        @(posedge clk);
        if (resetn) model_step(t, int'(p), int'(v));
        #1;
        compare_all();
    endtask

    // Asynchronous reset mid-cycle, then release with a tick on the release edge.
    task automatic reset_pulse();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_eq("rst_state",  int'(state),  0);
        check_eq("rst_x",      int'(x_pos),  0);
        check_eq("rst_height", int'(height), 0);
        check_eq("rst_landed", int'(landed), 0);
        @(negedge clk);
        @(negedge clk);
        resetn     = 1'b1;
        frame_tick = 1'b1;
        pitch      = 2'b00;
        volumn     = 1'b1;
        @(posedge clk);
        model_step(1'b1, 0, 1);
        #1;
        compare_all();
        check_eq("release_tick_ignored", int'(state), 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        frame_tick   = 1'b0;
        pitch        = 2'b00;
        volumn       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        reset_pulse();

        // debounce: the release tick was dropped, so history is still empty
        cycle(1, 2'b00, 1);
        check_eq("one_loud_idle", int'(state), 0);
        check_eq("one_loud_x", int'(x_pos), 0);
        cycle(0, 2'b11, 0);
        cycle(1, 2'b00, 1);
        check_eq("two_loud_walk", int'(state), 1);
        repeat (3) begin
            cycle(1, 2'b00, 1);
            cycle(0, 2'b01, 0);
        end
        check_eq("walk_x3", int'(x_pos), 3);

        // mid jump
        cycle(1, 2'b01, 1);
        check_eq("mid_rise", int'(state), 2);
        repeat (8) cycle(1, 2'b00, 1);
        check_eq("mid_apex", int'(height), 16);
        check_eq("mid_fall", int'(state), 3);
        repeat (8) cycle(1, 2'b00, 1);
        check_eq("mid_landed", int'(landed), 1);
        check_eq("mid_walk", int'(state), 1);
        cycle(0, 2'b00, 1);
        check_eq("landed_one_cycle", int'(landed), 0);

        // high jump with inputs dropped mid-rise
        cycle(1, 2'b11, 1);
        cycle(1, 2'b11, 1);
        repeat (15) cycle(1, 2'b00, 0);
        check_eq("high_apex", int'(height), 32);
        repeat (16) cycle(1, 2'b01, 0);
        check_eq("high_landed", int'(landed), 1);
        check_eq("high_idle", int'(state), 0);

        // walk to the wrap point
        cycle(1, 2'b00, 1);
        cycle(1, 2'b00, 1);
        for (int i = 0; i < 400 && m_x != 318; i++) cycle(1, 2'b00, 1);
        check_eq("x_318", int'(x_pos), 318);
        cycle(1, 2'b00, 1);
        cycle(1, 2'b00, 1);
        check_eq("x_wrap", int'(x_pos), 0);

        // lone loud frame
        repeat (3) cycle(1, 2'b00, 0);
        cycle(1, 2'b11, 1);
        cycle(1, 2'b11, 0);
        cycle(1, 2'b11, 0);
        check_eq("glitch_idle", int'(state), 0);

        // pitch 10 walks only
        repeat (4) cycle(1, 2'b10, 1);
        check_eq("p10_walk", int'(state), 1);

        // reset mid-rise at height 10
        cycle(1, 2'b01, 1);
        repeat (5) cycle(1, 2'b00, 1);
        check_eq("pre_reset_h10", int'(height), 10);
        reset_pulse();

        // randomized frames
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_pulse();
            end else begin
                cycle($urandom_range(0, 9) < 6,
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 9) < 6);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
